// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage ALU control path and the multiply/divide unit.
package muldiv_pkg;

    // 4-bit ALU control codes, shared with the ALU control decoder and the ALU.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1100;
    localparam logic [3:0] ALU_DIV  = 4'b1101;

    // Multiply/divide sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_e;

    // True for the control codes this unit executes; everything else is a single-cycle ALU op.
    function automatic logic is_muldiv_op(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage (master) and the multiply/divide unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       alu_ctrl_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    // Pipeline side: issues operations, observes busy/done and the HI/LO registers.
    modport master (
        output start_i, alu_ctrl_i, src_a_i, src_b_i, flush_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    // Unit side.
    modport slave (
        input  start_i, alu_ctrl_i, src_a_i, src_b_i, flush_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit holding the architectural HI/LO registers.
// Works on operand magnitudes (one radix-2 step per cycle for WIDTH cycles) and
// applies the result signs in a final SIGN cycle that also commits HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    muldiv_if.slave bus
);

    // Accumulator layout: [2*WIDTH:WIDTH] is the upper partial sum (MULT) or the
    // WIDTH+1 bit remainder (DIV); [WIDTH-1:0] is the multiplier (MULT) or the
    // dividend shifting out while quotient bits shift in (DIV).
    localparam int AW = 2 * WIDTH + 1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] opb_q;
    logic [AW-1:0]    acc_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             start_ok;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [AW-1:0]    acc_d;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0] quot_mag;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // Two's complement magnitude; the most-negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign start_ok = bus.start_i && !bus.flush_i && is_muldiv_op(bus.alu_ctrl_i);

    assign bus.busy_o = (state_q != ST_IDLE);
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;

    // One radix-2 step: shift-add for MULT, restoring trial subtract for DIV.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        mul_sum   = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        trial     = rem_shift - {1'b0, opb_q};
        acc_d     = acc_q;
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                acc_d = {trial, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {rem_shift, acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Signed HI/LO values committed on the SIGN -> IDLE edge.
    always_comb begin
        prod_mag = acc_q[2*WIDTH-1:0];
        prod_res = neg_res_q ? -prod_mag : prod_mag;
        quot_mag = acc_q[WIDTH-1:0];
        rem_mag  = acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            // Truncating division: quotient sign from the operands, remainder follows the dividend.
            hi_d = neg_rem_q ? -rem_mag : rem_mag;
            lo_d = neg_res_q ? -quot_mag : quot_mag;
        end else begin
            hi_d = prod_res[2*WIDTH-1:WIDTH];
            lo_d = prod_res[WIDTH-1:0];
        end
    end

    // Sequencer: latches operands, iterates WIDTH steps, signs and commits the result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: operand and accumulator registers are reset as well, so nothing from an
            // aborted operation survives reset.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values,
            // independent of statement order.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q   <= ST_CALC;
                        cnt_q     <= '0;
                        is_div_q  <= (bus.alu_ctrl_i == ALU_DIV);
                        // A zero divisor keeps the all-ones quotient unsigned.
                        neg_res_q <= (bus.src_a_i[WIDTH-1] ^ bus.src_b_i[WIDTH-1]) &&
                                     !((bus.alu_ctrl_i == ALU_DIV) && (bus.src_b_i == '0));
                        neg_rem_q <= bus.src_a_i[WIDTH-1];
                        opb_q     <= magnitude(bus.src_b_i);
                        acc_q     <= {{(WIDTH+1){1'b0}}, magnitude(bus.src_a_i)};
                    end
                end
                ST_CALC: begin
                    if (bus.flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= ST_SIGN;
                        end
                    end
                end
                ST_SIGN: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    if (!bus.flush_i) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
